// File: rtl/enemy_attack_ctrl.sv
// Per-enemy attack initiator: frame-paced IDLE -> WINDUP -> STRIKE -> COOLDOWN
// machine gated by proximity and liveness, with a saturating strike counter.
module enemy_attack_ctrl #(
  parameter int         id              = 0,
  parameter logic [8:0] ATTACK_RANGE    = 9'd20,
  parameter logic [7:0] WINDUP_FRAMES   = 8'd15,
  parameter logic [7:0] COOLDOWN_FRAMES = 8'd45
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       game_frame_clk_rising_edge,
  input  logic [8:0] Player_X,
  input  logic [8:0] Player_Y,
  input  logic [8:0] Enemy_X,
  input  logic [8:0] Enemy_Y,
  input  logic       Enemy_Alive,
  input  logic       Player_Alive,
  output logic       Enemy_Attack_On,
  output logic [1:0] Enemy_Attack_Phase,
  output logic [7:0] Enemy_Attack_Count
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WINDUP   = 2'd1,
    S_STRIKE   = 2'd2,
    S_COOLDOWN = 2'd3
  } state_e;

  function automatic logic [8:0] abs_diff(input logic [8:0] a, input logic [8:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : (v + 8'd1);
  endfunction

  // The enemy index only exists for instantiation symmetry.
  logic [31:0] unused_id;
  assign unused_id = id;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] count_q, count_d;
  logic [8:0] dx, dy;
  logic       in_range;
  logic       go;
  logic       frame;

  assign dx       = abs_diff(Enemy_X, Player_X);
  assign dy       = abs_diff(Enemy_Y, Player_Y);
  assign in_range = (dx <= ATTACK_RANGE) && (dy <= ATTACK_RANGE);
  assign go       = Enemy_Alive && Player_Alive;
  assign frame    = game_frame_clk_rising_edge;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    count_d = count_q;
    // Losing liveness aborts on any cycle, even if a frame edge coincides.
    if (!go) begin
      state_d = S_IDLE;
      cnt_d   = 8'd0;
    end else if (frame) begin
      unique case (state_q)
        S_IDLE: begin
          if (in_range) begin
            state_d = S_WINDUP;
            cnt_d   = 8'd0;
          end
        end
        S_WINDUP: begin
          if (!in_range) begin
            state_d = S_IDLE;
            cnt_d   = 8'd0;
          end else if (cnt_q == WINDUP_FRAMES - 8'd1) begin
            state_d = S_STRIKE;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        S_STRIKE: begin
          state_d = S_COOLDOWN;
          cnt_d   = 8'd0;
          count_d = sat_inc(count_q);
        end
        S_COOLDOWN: begin
          if (cnt_q == COOLDOWN_FRAMES - 8'd1) begin
            state_d = S_IDLE;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = 8'd0;
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      count_q <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      count_q <= count_d;
    end
  end

  assign Enemy_Attack_On    = (state_q == S_STRIKE);
  assign Enemy_Attack_Phase = state_q;
  assign Enemy_Attack_Count = count_q;

endmodule

// File: doc/enemy_attack_ctrl.md
# enemy_attack_ctrl

Per-enemy attack initiator: decides when one enemy strikes the player and drives the `Enemy_Attack_On` strobe that the per-enemy game-logic block samples to accumulate damage. It is instantiated once per enemy alongside the enemy's game-logic block. It runs a frame-paced IDLE → WINDUP → STRIKE → COOLDOWN machine gated by proximity and liveness. It also exports the attack phase for sprite selection and a strike counter for scoring and debug.

## Interface
Parameters:
- `id`, default 0: enemy index. Reserved for instantiation symmetry; no functional effect.
- `ATTACK_RANGE`, default 9'd20: inclusive per-axis reach, in pixels.
- `WINDUP_FRAMES`, default 8'd15: frames spent in WINDUP before a strike. Legal range 1..255.
- `COOLDOWN_FRAMES`, default 8'd45: frames spent in COOLDOWN after a strike. Legal range 1..255.

Ports:
- `Clk`  in  1  system clock. The block uses this single clock.
- `Reset`  in  1  synchronous, active-high reset.
- `game_frame_clk_rising_edge`  in  1  one-`Clk`-cycle pulse per game frame.
- `Player_X`, `Player_Y`  in  9 each  player top-left position.
- `Enemy_X`, `Enemy_Y`  in  9 each  enemy top-left position.
- `Enemy_Alive`  in  1  enemy is alive.
- `Player_Alive`  in  1  player is alive.
- `Enemy_Attack_On`  out  1  high while in STRIKE. Consumers sample it only on frame-edge cycles.
- `Enemy_Attack_Phase`  out  2  current state: 0 IDLE, 1 WINDUP, 2 STRIKE, 3 COOLDOWN.
- `Enemy_Attack_Count`  out  8  number of strikes delivered, saturating.

## Operation
- Proximity:
  - dx = Enemy_X ≥ Player_X ? Enemy_X−Player_X : Player_X−Enemy_X. All arithmetic is 9-bit unsigned and never wraps.
  - dy is computed the same way from the Y coordinates.
  - in_range = (dx ≤ ATTACK_RANGE) && (dy ≤ ATTACK_RANGE).
- Enable: go = Enemy_Alive && Player_Alive.
- Abort (highest priority, evaluated on every cycle, not only frame edges):
  - When go = 0, the next state is IDLE and cnt (8-bit frame counter) is cleared to 0.
  - A strike in progress is therefore never delivered.
- The remaining transitions happen only on cycles where game_frame_clk_rising_edge = 1 and go = 1:
  - IDLE: if in_range, go to WINDUP with cnt ← 0. Otherwise stay in IDLE.
  - WINDUP:
    - If not in_range, go to IDLE (cancel).
    - Else if cnt == WINDUP_FRAMES−1, go to STRIKE.
    - Else cnt ← cnt+1.
  - STRIKE: go to COOLDOWN with cnt ← 0. On this same cycle, Enemy_Attack_Count ← Enemy_Attack_Count+1, saturating at 255.
  - COOLDOWN: proximity is ignored.
    - If cnt == COOLDOWN_FRAMES−1, go to IDLE.
    - Else cnt ← cnt+1.
- Outputs are decoded from registered state only:
  - Enemy_Attack_On = (state == STRIKE).
  - Enemy_Attack_Phase = state encoding.
- Enemy_Attack_Count is cleared only by Reset. It is not cleared on enemy death or respawn.

## Timing
- Reset values: state IDLE, cnt 0, Enemy_Attack_On 0, Enemy_Attack_Phase 0, Enemy_Attack_Count 0.
- All state changes take effect on the `Clk` edge following the qualifying cycle. Outputs change one cycle after the qualifying input.
- STRIKE lasts exactly from one frame edge to the next. Enemy_Attack_On is therefore high on exactly one frame-edge cycle, so the consumer applies exactly one damage increment per strike.
- Cycle in frames, with default parameters, counting from the IDLE edge E0 where in_range is true:
  - WINDUP is entered at E0.
  - STRIKE is entered at E15.
  - The strike is sampled at E16, where the block moves to COOLDOWN.
  - IDLE is reached at E61.
  - WINDUP is re-entered at E62.
  - The next strike is sampled at E78.
  - Steady-state strike period while in range = WINDUP_FRAMES + COOLDOWN_FRAMES + 2 = 62 frames.
- Reset asserted mid-operation: the block returns to reset values on the next `Clk` edge, regardless of the frame pulse.
- Abort has priority over a simultaneous frame edge. If go falls on the same cycle as the STRIKE-sampling frame edge:
  - Enemy_Attack_On is still high on that cycle, because it is a registered decode, so the consumer counts that strike.
  - The block goes to IDLE.
  - Enemy_Attack_Count does not increment.
- Range boundary: dx = ATTACK_RANGE is in range; dx = ATTACK_RANGE+1 is out of range.
- A frame pulse asserted on consecutive cycles counts as separate frames. The block does not filter it.

## Test plan
- Basic cycle:
  - Stimulus: Reset, then both alive, Enemy (100,100), Player (110,90), frame pulse every 4 cycles.
  - Required: WINDUP after the 1st pulse; Enemy_Attack_On high across exactly one pulse (the 17th); Enemy_Attack_Count = 1; the next strike is sampled at the 79th pulse.
- Range edge:
  - Stimulus: Player (120,100) with Enemy (100,100), then Player (121,100).
  - Required: the first position enters WINDUP; the second stays in IDLE indefinitely with Count = 0.
- Cancel:
  - Stimulus: Player moves out of range at the 10th WINDUP frame.
  - Required: IDLE on that pulse, cnt = 0, no strike. Re-entering range needs a full 15-frame windup again.
- Death abort:
  - Stimulus: Enemy_Alive dropped mid-cycle, between frame pulses, while in STRIKE.
  - Required: Phase = 0 on the next cycle, Enemy_Attack_On = 0 at the next pulse, Count unchanged.
- Saturation / reset:
  - Stimulus: force 260 strikes with WINDUP_FRAMES = COOLDOWN_FRAMES = 1.
  - Required: Count = 255. Asserting Reset for one cycle while in COOLDOWN makes all outputs 0 on the next cycle.
